// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown timer: FSM state encoding and
// the prescaler width calculation.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Width of a counter spanning 0..div-1, never narrower than one bit.
    function automatic int presc_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle step strobe every TICK_DIV running cycles.
// The phase is held while run is low and restarts from zero on clear.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic step
);

    localparam int            PW   = presc_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        step  = run && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Single-clock countdown timer with pause, optional auto-reload and
// expiry signalling; count steps are gated by an internal prescaler strobe.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] start_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tick,
    output logic             expired,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tick_q, tick_d;
    logic             expired_q, expired_d;
    logic             presc_run;
    logic             presc_clear;
    logic             step;

    // A pausing cycle does not advance the prescaler, so the phase on resume
    // is exactly the phase seen on the last running cycle.
    assign presc_run = (state_q == ST_RUN) && enable && !load;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (presc_run),
        .clear  (presc_clear),
        .step   (step)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        tick_d      = 1'b0;
        expired_d   = 1'b0;
        presc_clear = 1'b0;

        if (load) begin
            count_d     = start_value;
            reload_d    = start_value;
            presc_clear = 1'b1;
            if (start_value == '0) begin
                state_d = ST_IDLE;
            end else if (enable) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_PAUSE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_PAUSE;
                    end else if (step) begin
                        tick_d = 1'b1;
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            expired_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d     = '0;
                                state_d     = ST_DONE;
                                presc_clear = 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign expired = expired_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Parametrised, single-clock countdown timer. It replaces the fixed 8-bit down counter that ran on a derived slow clock.
- Counts down from a loaded value; each step is gated by an internal prescaler strobe, so no derived clock exists.
- Supports pause/resume, optional auto-reload, and expiry/done signalling.
- Sits between user controls (switch/button-derived load, enable) and the display/alarm logic.

Parameters:
WIDTH, 8, bit width of count, start_value and reload register (>=2)
TICK_DIV, 50000000, clk cycles per count step (>=1); prescaler width is a derived localparam, clog2 of TICK_DIV, minimum 1

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  reset, asynchronous, active-low
load  input  1  synchronous load strobe/level; highest priority
start_value  input  WIDTH  value captured on load
enable  input  1  level; 1 = run, 0 = pause
auto_reload  input  1  1 = on expiry reload from reload register and keep running
count  output  WIDTH  current count
running  output  1  high while state is RUN
tick  output  1  one-cycle pulse, coincident with each new stepped count value
expired  output  1  one-cycle pulse on each expiry
done  output  1  level, high while state is DONE

Behaviour:
- reset_n low: immediately (no clock edge needed) sets count=0, reload_reg=0, prescaler=0, state=IDLE, and tick/expired/done/running=0.
- States: IDLE, RUN, PAUSE, DONE.
- Prescaler: advances only in RUN. It asserts step when at TICK_DIV-1, then wraps to 0.
  - Held in PAUSE.
  - Cleared on load and on entry to DONE.
  - TICK_DIV=1: step every RUN cycle.
- load=1 in any state (overrides everything else):
  - count<=start_value, reload_reg<=start_value, prescaler<=0.
  - Next state: IDLE if start_value==0; otherwise RUN if enable=1, PAUSE if enable=0.
  - No tick/expired pulse that cycle.
- IDLE: count=0; waits for load; enable and auto_reload ignored.
- RUN:
  - enable=0: go to PAUSE. Pause wins over a coincident step; no decrement that cycle.
  - step with count>1: count<=count-1, tick next cycle.
  - step with count==1, auto_reload=0: count<=0, state<=DONE, tick and expired both pulse next cycle.
  - step with count==1, auto_reload=1: count<=reload_reg, stay RUN, tick and expired pulse; count never shows 0.
  - auto_reload is sampled at the step cycle only.
- PAUSE: count and prescaler hold; enable=1 goes to RUN, resuming from the held prescaler phase.
- DONE: count saturates at 0, done=1, enable ignored; leaves only via load or reset.
- Arithmetic: unsigned. Count never wraps below 0 and never decrements when 0.
- Outputs: all registered; no combinational path from inputs to outputs.
- Latency: load to new count = 1 cycle; step edge to tick/new count = 1 cycle.

Decomposition:
- Package countdown_pkg: 2-bit state typedef (IDLE=0, RUN=1, PAUSE=2, DONE=3) and the prescaler-width helper function.
- Sub-module tick_prescaler:
  - Parameter: TICK_DIV.
  - Ports: clk, reset_n, run, clear → step.
- The top holds the FSM, count and reload registers.

Test Plan (WIDTH=8, TICK_DIV=4 unless noted):
1. Reset, load 3 with enable=1 → count 3,2,1,0 at 4-clk intervals. tick with each change; expired single pulse with count=0; done=1 and running=0 after 12 clks.
2. Load 10, enable=1, drop enable after 6 clks → count holds 9, running=0. Re-enable → next step exactly 2 clks after resume.
3. Load 2, auto_reload=1 → count 2,1,2,1… ; expired pulses every 8 clks; done never asserts.
4. Running at count 7, load 5 → count=5 next clk, prescaler restarted, next step 4 clks later. Load 0 → IDLE, count 0, no tick/expired.
5. In DONE, toggle enable and auto_reload → count stays 0, done stays 1. Load 1 → RUN; expiry after 4 clks.
6. Assert reset_n low mid-RUN between clock edges → count=0 and state IDLE without a clock edge. Repeat scenario 1 with TICK_DIV=1 → count decrements every cycle.
